// File: rtl/fp_addsub_normalizer.sv
// Post-add normalize-and-pack stage: renormalizes the raw mantissa sum and packs an IEEE-754 single.
// Optional FP_NORM_LZC_EN replaces the iterative left-shift loop with a one-cycle leading-zero count plus barrel shift.
module fp_addsub_normalizer #(
  parameter int MANT_W   = 24,
  parameter int EXP_W    = 8,
  parameter int RESULT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MANT_W-1:0]   mant_sum,
  input  logic                carry,
  input  logic                op,
  input  logic [EXP_W-1:0]    exp_in,
  input  logic                sign_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] result,
  output logic                overflow,
  output logic                underflow,
  output logic                zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  state_t                state_q, state_d;
  logic [MANT_W-1:0]     mant_q, mant_d;
  logic [EXP_W-1:0]      exp_q, exp_d;
  logic                  sign_q, sign_d;
  logic                  op_q, op_d;
  logic                  carry_q, carry_d;
  logic [RESULT_W-1:0]   result_q, result_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  zero_q, zero_d;

  logic [MANT_W-1:0]     prep_mant_s;
  logic                  prep_sign_s;
  logic [MANT_W-1:0]     shift_mant_s;
  logic [EXP_W-1:0]      shift_exp_s;
  logic                  norm_flush_s;

  // A negative difference arrives as a two's-complement magnitude with no carry-out.
  assign prep_mant_s = (op_q && !carry_q) ? (~mant_q + MANT_W'(1)) : mant_q;
  assign prep_sign_s = (op_q && !carry_q) ? ~sign_q : sign_q;

`ifdef FP_NORM_LZC_EN
  localparam int LZC_W = $clog2(MANT_W);

  // Highest set bit wins; NORM is only entered with a nonzero mantissa.
  function automatic logic [LZC_W-1:0] lzc_f(input logic [MANT_W-1:0] m);
    lzc_f = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (m[i]) begin
        lzc_f = LZC_W'(MANT_W - 1 - i);
      end
    end
  endfunction

  logic [LZC_W-1:0] lzc_s;
  logic [EXP_W-1:0] lzc_ext_s;

  assign lzc_s        = lzc_f(mant_q);
  assign lzc_ext_s    = EXP_W'(lzc_s);
  assign shift_mant_s = mant_q << lzc_s;
  assign shift_exp_s  = exp_q - lzc_ext_s;
  assign norm_flush_s = (lzc_ext_s >= exp_q);
`else
  assign shift_mant_s = mant_q << 1;
  assign shift_exp_s  = exp_q - EXP_ONE;
  // Exponent 0 is treated like 1 so a denormal input can never wrap the exponent.
  assign norm_flush_s = (exp_q <= EXP_ONE);
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      op_q        <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      zero_q      <= zero_d;
    end
  end

  // Next-state, classification, normalization and packing.
  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    op_d        = op_q;
    carry_d     = carry_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d      = mant_sum;
          carry_d     = carry;
          op_d        = op;
          exp_d       = exp_in;
          sign_d      = sign_in;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          zero_d      = 1'b0;
          state_d     = PREP;
        end else begin
          state_d = IDLE;
        end
      end

      PREP: begin
        state_d = DONE;
        if (!op_q && carry_q) begin
          if (exp_q >= (EXP_MAX - EXP_ONE)) begin
            overflow_d = 1'b1;
            result_d   = {sign_q, EXP_MAX, {(MANT_W-1){1'b0}}};
          end else begin
            result_d = {sign_q, exp_q + EXP_ONE, mant_q[MANT_W-1:1]};
          end
        end else if (prep_mant_s == '0) begin
          zero_d   = 1'b1;
          result_d = '0;
        end else if (exp_q == EXP_MAX) begin
          overflow_d = 1'b1;
          result_d   = {prep_sign_s, EXP_MAX, {(MANT_W-1){1'b0}}};
        end else if (prep_mant_s[MANT_W-1]) begin
          result_d = {prep_sign_s, exp_q, prep_mant_s[MANT_W-2:0]};
        end else begin
          mant_d  = prep_mant_s;
          sign_d  = prep_sign_s;
          state_d = NORM;
        end
      end

      NORM: begin
        if (norm_flush_s) begin
          underflow_d = 1'b1;
          result_d    = {sign_q, {(RESULT_W-1){1'b0}}};
          state_d     = DONE;
        end else begin
          mant_d = shift_mant_s;
          exp_d  = shift_exp_s;
          if (shift_mant_s[MANT_W-1]) begin
            result_d = {sign_q, shift_exp_s, shift_mant_s[MANT_W-2:0]};
            state_d  = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          zero_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign zero      = zero_q;

endmodule
